// File: rtl/walk_light_ctrl_pkg.sv
// Shared types and constants for the pedestrian walk-light controller.
// State encoding is exported on state_o, so keep these values stable.
package walk_light_ctrl_pkg;

  typedef enum logic [2:0] {
    CAR_GREEN  = 3'd0,
    CAR_YELLOW = 3'd1,
    ALL_RED    = 3'd2,
    WALK       = 3'd3,
    WALK_FLASH = 3'd4,
    CLEAR_RED  = 3'd5
  } wl_state_e;

  localparam int unsigned DEF_G_SEC     = 4;
  localparam int unsigned DEF_Y_SEC     = 2;
  localparam int unsigned DEF_AR_SEC    = 1;
  localparam int unsigned DEF_CR_SEC    = 1;
  localparam int unsigned DEF_W_SEC     = 5;
  localparam int unsigned DEF_WF_SEC    = 3;
  localparam int unsigned DEF_BLINK_CYC = 12500000;

  // The external timer takes a single BCD-style digit: keep loads in 1..9.
  function automatic logic [3:0] clamp_sec(input int unsigned sec);
    if (sec == 0)
      clamp_sec = 4'd1;
    else if (sec > 9)
      clamp_sec = 4'd9;
    else
      clamp_sec = 4'(sec);
  endfunction

endpackage

// File: rtl/walk_light_ctrl_ped_btn_sync.sv
// Two-flop synchronizer for the raw push-button plus a one-cycle
// rising-edge pulse taken from the synchronized (metastability-safe) stage.
module ped_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic rise_o
);

  logic sync1, sync2, sync2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= btn_in;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise_o = sync2 & ~sync2_d;

endmodule

// File: rtl/walk_light_ctrl.sv
// Pedestrian crossing controller: sequences car/walk lamps against an
// external seconds countdown timer, loading it once on each state entry.
//
// state      | meaning
// CAR_GREEN  | cars go; waits for timer expiry and a pedestrian request
// CAR_YELLOW | cars warned to stop
// ALL_RED    | everything red before the walk phase
// WALK       | steady walk lamp
// WALK_FLASH | walk lamp blinking, crossing ending
// CLEAR_RED  | everything red while the crossing clears
import walk_light_ctrl_pkg::*;

module walk_light_ctrl #(
  parameter int unsigned G_SEC     = DEF_G_SEC,
  parameter int unsigned Y_SEC     = DEF_Y_SEC,
  parameter int unsigned AR_SEC    = DEF_AR_SEC,
  parameter int unsigned CR_SEC    = DEF_CR_SEC,
  parameter int unsigned W_SEC     = DEF_W_SEC,
  parameter int unsigned WF_SEC    = DEF_WF_SEC,
  parameter int unsigned BLINK_CYC = DEF_BLINK_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_btn,
  input  logic [3:0] tmr_cur_sec,
  output logic       tmr_set,
  output logic [3:0] tmr_new_sec,
  output logic       car_r,
  output logic       car_y,
  output logic       car_g,
  output logic       walk_g,
  output logic       walk_r,
  output logic       ped_wait,
  output logic [2:0] state_o
);

  localparam int CNT_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYC - 1);

  localparam logic [3:0] G_T  = clamp_sec(G_SEC);
  localparam logic [3:0] Y_T  = clamp_sec(Y_SEC);
  localparam logic [3:0] AR_T = clamp_sec(AR_SEC);
  localparam logic [3:0] CR_T = clamp_sec(CR_SEC);
  localparam logic [3:0] W_T  = clamp_sec(W_SEC);
  localparam logic [3:0] WF_T = clamp_sec(WF_SEC);

  wl_state_e        state, state_nxt;
  logic             load_q;
  logic             ped_req;
  logic             btn_rise;
  logic             expired;
  logic             enter_walk;
  logic             enter_flash;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink;

  ped_btn_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .btn_in (ped_btn),
    .rise_o (btn_rise)
  );

  // The timer still shows the previous state's 0 during the load cycle.
  assign expired     = ~load_q && (tmr_cur_sec == 4'd0);
  assign enter_walk  = (state_nxt == WALK) && (state != WALK);
  assign enter_flash = (state_nxt == WALK_FLASH) && (state != WALK_FLASH);

  always_comb begin
    state_nxt = state;
    case (state)
      CAR_GREEN:  if (expired && ped_req) state_nxt = CAR_YELLOW;
      CAR_YELLOW: if (expired) state_nxt = ALL_RED;
      ALL_RED:    if (expired) state_nxt = WALK;
      WALK:       if (expired) state_nxt = WALK_FLASH;
      WALK_FLASH: if (expired) state_nxt = CLEAR_RED;
      CLEAR_RED:  if (expired) state_nxt = CAR_GREEN;
      default:    state_nxt = CAR_GREEN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= CAR_GREEN;
      load_q <= 1'b1;
    end else begin
      state  <= state_nxt;
      load_q <= (state_nxt != state);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ped_req <= 1'b0;
    else if (enter_walk)
      ped_req <= 1'b0;
    else if (btn_rise && (state != WALK) && (state != WALK_FLASH))
      ped_req <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink     <= 1'b1;
    end else if (enter_flash) begin
      blink_cnt <= '0;
      blink     <= 1'b1;
    end else if (state == WALK_FLASH) begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    car_r       = 1'b0;
    car_y       = 1'b0;
    car_g       = 1'b0;
    walk_g      = 1'b0;
    walk_r      = 1'b0;
    tmr_new_sec = G_T;
    case (state)
      CAR_GREEN:  begin car_g = 1'b1; walk_r = 1'b1; tmr_new_sec = G_T;  end
      CAR_YELLOW: begin car_y = 1'b1; walk_r = 1'b1; tmr_new_sec = Y_T;  end
      ALL_RED:    begin car_r = 1'b1; walk_r = 1'b1; tmr_new_sec = AR_T; end
      WALK:       begin car_r = 1'b1; walk_g = 1'b1; tmr_new_sec = W_T;  end
      WALK_FLASH: begin car_r = 1'b1; walk_g = blink; tmr_new_sec = WF_T; end
      CLEAR_RED:  begin car_r = 1'b1; walk_r = 1'b1; tmr_new_sec = CR_T; end
      default:    begin car_g = 1'b1; walk_r = 1'b1; tmr_new_sec = G_T;  end
    endcase
  end

  assign tmr_set  = load_q;
  assign ped_wait = ped_req;
  assign state_o  = state;

endmodule

// File: tb/tb_walk_light_ctrl.sv
// Bench for walk_light_ctrl: behavioural timer, phase/age reference model
// compared every cycle, plus directed literal checks and random button traffic.
module tb_walk_light_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_btn = 1'b0;
  logic [3:0] tmr_cur_sec = 4'd0;
  logic       tmr_set;
  logic [3:0] tmr_new_sec;
  logic       car_r, car_y, car_g, walk_g, walk_r, ped_wait;
  logic [2:0] state_o;

  logic       tmr_set2;
  logic [3:0] tmr_new_sec2;
  logic       car_r2, car_y2, car_g2, walk_g2, walk_r2, ped_wait2;
  logic [2:0] state_o2;

  int errors = 0;
  int checks = 0;
  int tick = 0;
  int seen_w2 = 0;
  int seen_y2 = 0;

  always #5 clk = ~clk;

  walk_light_ctrl #(.BLINK_CYC(4)) dut (
    .clk(clk), .rst(rst), .ped_btn(ped_btn), .tmr_cur_sec(tmr_cur_sec),
    .tmr_set(tmr_set), .tmr_new_sec(tmr_new_sec),
    .car_r(car_r), .car_y(car_y), .car_g(car_g),
    .walk_g(walk_g), .walk_r(walk_r), .ped_wait(ped_wait), .state_o(state_o)
  );

  // Timer frozen at 0: every state lasts two cycles, exercising the clamps.
  walk_light_ctrl #(.W_SEC(0), .Y_SEC(12), .BLINK_CYC(4)) dut2 (
    .clk(clk), .rst(rst), .ped_btn(ped_btn), .tmr_cur_sec(4'd0),
    .tmr_set(tmr_set2), .tmr_new_sec(tmr_new_sec2),
    .car_r(car_r2), .car_y(car_y2), .car_g(car_g2),
    .walk_g(walk_g2), .walk_r(walk_r2), .ped_wait(ped_wait2), .state_o(state_o2)
  );

  // External countdown timer: load on set, one second per 10 clocks, hold at 0.
  always @(posedge clk) begin
    if (tmr_set) begin
      tmr_cur_sec <= tmr_new_sec;
      tick <= 0;
    end else if (tick == 9) begin
      tick <= 0;
      if (tmr_cur_sec != 0) tmr_cur_sec <= tmr_cur_sec - 4'd1;
    end else begin
      tick <= tick + 1;
    end
  end

  // Reference model: phase index in the walk sequence and cycles spent in it.
  int dur [6] = '{4, 2, 1, 5, 3, 1};
  int m_phase = 0;
  int m_age = 0;
  bit m_req = 0;
  bit btn_hist [4] = '{0, 0, 0, 0};
  bit m_rise, m_exp, m_adv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_age = 0;
      m_req = 0;
      btn_hist = '{0, 0, 0, 0};
    end else begin
      // Button edge becomes visible two clocks after it is first sampled.
      m_rise = btn_hist[2] && !btn_hist[3];
      btn_hist[3] = btn_hist[2];
      btn_hist[2] = btn_hist[1];
      btn_hist[1] = ped_btn;
      m_exp = (m_age != 0) && (tmr_cur_sec == 0);
      m_adv = m_exp && (m_phase != 0 || m_req);
      if (m_adv && m_phase == 2)
        m_req = 0;
      else if (m_rise && m_phase != 3 && m_phase != 4)
        m_req = 1;
      if (m_adv) begin
        m_phase = (m_phase + 1) % 6;
        m_age = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
  end

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    chk("state_o", int'(state_o), m_phase);
    chk("tmr_set", int'(tmr_set), int'(m_age == 0));
    chk("tmr_new_sec", int'(tmr_new_sec), dur[m_phase]);
    chk("car_g", int'(car_g), int'(m_phase == 0));
    chk("car_y", int'(car_y), int'(m_phase == 1));
    chk("car_r", int'(car_r), int'(m_phase >= 2));
    chk("walk_r", int'(walk_r), int'(m_phase <= 2 || m_phase == 5));
    chk("walk_g", int'(walk_g),
        int'(m_phase == 3 || (m_phase == 4 && ((m_age / 4) % 2) == 0)));
    chk("ped_wait", int'(ped_wait), int'(m_req));
    if (!rst && state_o2 == 3'd3) begin
      chk("clamp_w0", int'(tmr_new_sec2), 1);
      seen_w2 = 1;
    end
    if (!rst && state_o2 == 3'd1) begin
      chk("clamp_y12", int'(tmr_new_sec2), 9);
      seen_y2 = 1;
    end
  end

  task automatic wait_state(input int s, input int budget, input string nm);
    int k = 0;
    while (int'(state_o) != s && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, int'(state_o), s);
  endtask

  task automatic pulse_btn(input int n);
    ped_btn = 1'b1;
    repeat (n) @(negedge clk);
    ped_btn = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_car_g", int'(car_g), 1);
    chk("rst_walk_r", int'(walk_r), 1);
    chk("rst_walk_g", int'(walk_g), 0);
    chk("rst_tmr_set", int'(tmr_set), 1);
    chk("rst_new_sec", int'(tmr_new_sec), 4);
    chk("rst_ped_wait", int'(ped_wait), 0);
    chk("rst_state", int'(state_o), 0);
    #1 rst = 1'b0;
    #1;
    chk("cyc1_tmr_set", int'(tmr_set), 1);
    chk("cyc1_new_sec", int'(tmr_new_sec), 4);

    repeat (80) @(negedge clk);
    chk("idle_state", int'(state_o), 0);
    chk("idle_tmr_set", int'(tmr_set), 0);
    chk("idle_car_g", int'(car_g), 1);

    // Press while green is already expired.
    ped_btn = 1'b1;
    k = 0;
    while (!ped_wait && k < 6) begin
      @(negedge clk);
      k++;
      if (k == 2) ped_btn = 1'b0;
    end
    ped_btn = 1'b0;
    chk("req_latency", k, 3);
    @(negedge clk);
    chk("yellow_after_req", int'(state_o), 1);
    chk("yellow_tmr_set", int'(tmr_set), 1);
    chk("yellow_new_sec", int'(tmr_new_sec), 2);

    wait_state(2, 40, "reach_all_red");
    wait_state(3, 40, "reach_walk");
    chk("walk_ped_wait", int'(ped_wait), 0);
    chk("walk_new_sec", int'(tmr_new_sec), 5);
    pulse_btn(2);
    repeat (3) @(negedge clk);
    chk("walk_press_ignored", int'(ped_wait), 0);
    wait_state(4, 80, "reach_flash");
    chk("flash_blink0", int'(walk_g), 1);
    repeat (4) @(negedge clk);
    chk("flash_blink1", int'(walk_g), 0);
    repeat (4) @(negedge clk);
    chk("flash_blink2", int'(walk_g), 1);
    pulse_btn(2);
    repeat (3) @(negedge clk);
    chk("flash_press_ignored", int'(ped_wait), 0);
    wait_state(5, 60, "reach_clear_red");
    wait_state(0, 40, "reach_green");

    // Press while the green timer still shows 3 seconds.
    k = 0;
    while (tmr_cur_sec != 4'd3 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("green_cur3", int'(tmr_cur_sec), 3);
    ped_btn = 1'b1;
    k = 0;
    while (!ped_wait && k < 6) begin
      @(negedge clk);
      k++;
      if (k == 2) ped_btn = 1'b0;
    end
    ped_btn = 1'b0;
    chk("req_latency2", int'(k <= 3), 1);
    k = 0;
    while (tmr_cur_sec != 4'd0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("green_wait_expiry", int'(state_o), 0);
    @(negedge clk);
    chk("yellow_after_expiry", int'(state_o), 1);
    wait_state(0, 300, "return_green");
    repeat (60) @(negedge clk);
    chk("green_holds", int'(state_o), 0);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) ped_btn = ~ped_btn;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
      end
    end
    ped_btn = 1'b0;

    // Reset in the middle of the flashing-walk phase.
    wait_state(0, 400, "pre_flash_green");
    repeat (2) @(negedge clk);
    pulse_btn(2);
    wait_state(4, 600, "reach_flash2");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_car_g", int'(car_g), 1);
    chk("mid_rst_car_r", int'(car_r), 0);
    chk("mid_rst_walk_r", int'(walk_r), 1);
    chk("mid_rst_walk_g", int'(walk_g), 0);
    chk("mid_rst_ped_wait", int'(ped_wait), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_tmr_set", int'(tmr_set), 1);
    @(negedge clk);
    chk("post_rst_tmr_clr", int'(tmr_set), 0);

    chk("seen_walk_clamp", seen_w2, 1);
    chk("seen_yellow_clamp", seen_y2, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
